// File: rtl/closest_lane_seq_pkg.sv
// Shared types and width helpers for the closest-to-mean byte-lane sequencer.
package closest_lane_seq_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  function automatic int sum_w(input int w);
    return w + 2;
  endfunction

  function automatic int dev_w(input int w);
    return w + 3;
  endfunction

  function automatic int sq_w(input int w);
    return 2 * w + 4;
  endfunction

  localparam int SUM_W = sum_w(LANE_W);
  localparam int DEV_W = dev_w(LANE_W);
  localparam int SQ_W  = sq_w(LANE_W);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

endpackage

// File: rtl/closest_lane_seq_lane_sqdev.sv
// Squared deviation of one lane from the mean: (S - 4x)^2, exact, zero latency.
// Purely combinational, no flow control.
module lane_sqdev
  import closest_lane_seq_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic [sum_w(W)-1:0] S,
  input  logic [W-1:0]        x,
  output logic [sq_w(W)-1:0]  sq
);

  localparam int SUMW = sum_w(W);
  localparam int DEVW = dev_w(W);
  localparam int SQW  = sq_w(W);

  logic signed [DEVW-1:0] dev;
  logic        [SUMW-1:0] mag;

  // |dev| <= 3*(2^W-1) fits in SUMW bits, so squaring the magnitude is exact in SQW bits.
  always_comb begin
    dev = $signed({1'b0, S}) - $signed({1'b0, x, 2'b00});
    mag = dev[DEVW-1] ? SUMW'(-dev) : SUMW'(dev);
    sq  = SQW'(mag) * SQW'(mag);
  end

endmodule

// File: rtl/closest_lane_seq.sv
// Picks the byte lane closest to the lane mean, one lane per cycle through a shared unit.
// Result valid 4 cycles after accept; result held until out_ready, no input accepted meanwhile.
module closest_lane_seq
  import closest_lane_seq_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*W-1:0]       din,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_idx,
  output logic [sq_w(W)-1:0]   out_sq,
  output logic [sum_w(W)-1:0]  out_sum,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_done
);

  localparam int SUMW = sum_w(W);
  localparam int SQW  = sq_w(W);
  localparam int KW   = $clog2(LANES);

  state_t          state;
  logic [KW-1:0]   k;
  logic [4*W-1:0]  word_q;
  logic            rdy_q;
  logic [SQW-1:0]  best_sq;
  logic [1:0]      best_idx;

  logic [SUMW-1:0] din_sum;
  logic [W-1:0]    lane_x;
  logic [SQW-1:0]  lane_sq;
  logic            take;
  logic [SQW-1:0]  nxt_sq;
  logic [1:0]      nxt_idx;

  always_comb begin
    din_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      din_sum = din_sum + SUMW'(din[i*W +: W]);
    end
  end

  // Lane 0 sits in the most significant byte of the word.
  always_comb begin
    lane_x = word_q[(LANES - 1 - int'(k)) * W +: W];
  end

  lane_sqdev #(.W(W)) u_sqdev (
    .S  (out_sum),
    .x  (lane_x),
    .sq (lane_sq)
  );

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    take    = (k == '0) || (lane_sq < best_sq);
    nxt_sq  = take ? lane_sq : best_sq;
    nxt_idx = take ? 2'(k) : best_idx;
  end

  assign in_ready  = rdy_q && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      k          <= '0;
      word_q     <= '0;
      best_sq    <= '0;
      best_idx   <= '0;
      out_idx    <= '0;
      out_sq     <= '0;
      out_sum    <= '0;
      words_done <= '0;
    end else if (flush) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (in_valid && in_ready) begin
            word_q  <= din;
            out_sum <= din_sum;
            k       <= '0;
            rdy_q   <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          best_sq  <= nxt_sq;
          best_idx <= nxt_idx;
          k        <= k + 1'b1;
          if (k == KW'(LANES - 1)) begin
            out_sq  <= nxt_sq;
            out_idx <= nxt_idx;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            words_done <= words_done + 1'b1;
            rdy_q      <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
